// File: rtl/trace_controller_if.sv
// Trace write-back bus between the core (master) and trace_controller (slave).
// Signal suffixes are taken from the controller's point of view.
interface trace_controller_if #(
  parameter int INFO_W = 8
) ();
  logic              trace_valid_i;
  logic [31:0]       trace_address_i;
  logic [4:0]        trace_destination_i;
  logic [31:0]       trace_result_i;
  logic [INFO_W-1:0] trace_info_i;
  logic              trace_stall_o;

  modport master (
    output trace_valid_i,
    output trace_address_i,
    output trace_destination_i,
    output trace_result_i,
    output trace_info_i,
    input  trace_stall_o
  );

  modport slave (
    input  trace_valid_i,
    input  trace_address_i,
    input  trace_destination_i,
    input  trace_result_i,
    input  trace_info_i,
    output trace_stall_o
  );
endinterface

// File: rtl/trace_controller.sv
// Buffers retired-instruction trace records in a FIFO and streams each one
// out as a three-beat packet: header, address, result.
module trace_controller #(
  parameter int DEPTH  = 8,
  parameter int INFO_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  trace_controller_if.slave trace,
  input  logic              enable_i,
  input  logic              flush_i,
  output logic              tx_valid_o,
  output logic [31:0]       tx_data_o,
  output logic              tx_last_o,
  input  logic              tx_ready_i,
  output logic [15:0]       dropped_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    ADDRESS,
    RESULT
  } state_t;

  typedef struct packed {
    logic [31:0]       address;
    logic [4:0]        destination;
    logic [31:0]       result;
    logic [INFO_W-1:0] info;
  } record_t;

  record_t       mem_q [DEPTH];
  record_t       rec_in;
  record_t       head;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    seq_q, seq_d;
  logic          flush_pending_q, flush_pending_d;
  logic [15:0]   dropped_q, dropped_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          drop;
  logic          clear;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Stall depends only on registered state, so a pop at full frees the slot a cycle later.
  assign trace.trace_stall_o = full | flush_pending_q;

  assign push = trace.trace_valid_i & enable_i & ~full & ~flush_pending_q;
  assign drop = trace.trace_valid_i & ~enable_i;

  assign rec_in = {trace.trace_address_i, trace.trace_destination_i,
                   trace.trace_result_i, trace.trace_info_i};
  assign head   = mem_q[rd_ptr_q[AW-1:0]];

  assign dropped_o = dropped_q;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= rec_in;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      seq_q           <= '0;
      flush_pending_q <= 1'b0;
      dropped_q       <= '0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      seq_q           <= seq_d;
      flush_pending_q <= flush_pending_d;
      dropped_q       <= dropped_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    seq_d           = seq_q;
    flush_pending_d = flush_pending_q;
    dropped_d       = dropped_q;
    clear           = 1'b0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (drop && (dropped_q != 16'hFFFF)) begin
      dropped_d = dropped_q + 16'd1;
    end
    if (flush_i && (state_q != IDLE)) begin
      flush_pending_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (flush_i) begin
          clear = 1'b1;
        end else if (!empty) begin
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (tx_ready_i) begin
          state_d = ADDRESS;
        end
      end
      ADDRESS: begin
        if (tx_ready_i) begin
          state_d = RESULT;
        end
      end
      RESULT: begin
        // A flush seen during the packet takes effect here instead of popping.
        if (tx_ready_i) begin
          state_d = IDLE;
          if (flush_pending_q || flush_i) begin
            clear = 1'b1;
          end else begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            seq_d    = seq_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (clear) begin
      wr_ptr_d        = '0;
      rd_ptr_d        = '0;
      seq_d           = '0;
      flush_pending_d = 1'b0;
    end
  end

  always_comb begin
    tx_valid_o = 1'b0;
    tx_data_o  = '0;
    tx_last_o  = 1'b0;
    case (state_q)
      HEADER: begin
        tx_valid_o = 1'b1;
        tx_data_o  = {seq_q, 3'b000, head.destination, 16'(head.info)};
      end
      ADDRESS: begin
        tx_valid_o = 1'b1;
        tx_data_o  = head.address;
      end
      RESULT: begin
        tx_valid_o = 1'b1;
        tx_data_o  = head.result;
        tx_last_o  = 1'b1;
      end
      default: begin
        tx_valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_trace_controller.sv
// Self-checking bench for trace_controller: directed scenarios plus random
// traffic, all compared against a queue-based packet model.
module tb_trace_controller;

  localparam int DEPTH  = 8;
  localparam int INFO_W = 8;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        enable_i;
  logic        flush_i;
  logic        tx_valid_o;
  logic [31:0] tx_data_o;
  logic        tx_last_o;
  logic        tx_ready_i;
  logic [15:0] dropped_o;

  always #5 clk_i = ~clk_i;

  trace_controller_if #(.INFO_W(INFO_W)) trace_bus ();

  trace_controller #(.DEPTH(DEPTH), .INFO_W(INFO_W)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .trace      (trace_bus),
    .enable_i   (enable_i),
    .flush_i    (flush_i),
    .tx_valid_o (tx_valid_o),
    .tx_data_o  (tx_data_o),
    .tx_last_o  (tx_last_o),
    .tx_ready_i (tx_ready_i),
    .dropped_o  (dropped_o)
  );

  typedef struct {
    logic [31:0]       address;
    logic [4:0]        dest;
    logic [31:0]       result;
    logic [INFO_W-1:0] info;
  } rec_t;

  // Model: records waiting in order, plus where the current packet stands.
  rec_t  model_q[$];
  int    m_seq;
  bit    m_busy;
  int    m_beat;
  bit    m_pending;
  int    m_dropped;
  int    hdr_seqs[$];

  int    n_checks;
  int    n_fail;

  logic [31:0] obs_valid, obs_data, obs_last, obs_stall, obs_dropped;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  function automatic rec_t mkRec(input logic [31:0] a, input logic [4:0] d,
                                 input logic [31:0] r, input logic [INFO_W-1:0] i);
    rec_t x;
    x.address = a;
    x.dest    = d;
    x.result  = r;
    x.info    = i;
    return x;
  endfunction

  function automatic rec_t randRec();
    return mkRec($urandom, 5'($urandom), $urandom, INFO_W'($urandom));
  endfunction

  function automatic logic [31:0] beatData(input rec_t r, input int beat, input int seq);
    if (beat == 0)
      return (32'(seq % 256) << 24) | (32'(r.dest) << 16) | 32'(r.info);
    else if (beat == 1)
      return r.address;
    else
      return r.result;
  endfunction

  task automatic modelReset();
    model_q.delete();
    m_seq     = 0;
    m_busy    = 0;
    m_beat    = 0;
    m_pending = 0;
    m_dropped = 0;
  endtask

  // One clock cycle: sample and check at the falling edge, drive new inputs,
  // advance the model to what the next rising edge should produce.
  task automatic applyStimulus(input bit valid, input bit en, input bit flush,
                               input bit ready, input rec_t r, output bit pushed);
    bit exp_stall;
    bit push;
    bit clear;
    @(negedge clk_i);
    obs_valid   = 32'(tx_valid_o);
    obs_data    = tx_data_o;
    obs_last    = 32'(tx_last_o);
    obs_stall   = 32'(trace_bus.trace_stall_o);
    obs_dropped = 32'(dropped_o);

    exp_stall = (model_q.size() == DEPTH) || m_pending;
    checkOutput("stall", obs_stall, 32'(exp_stall));
    checkOutput("tx_valid", obs_valid, 32'(m_busy));
    checkOutput("dropped", obs_dropped, 32'(m_dropped));
    if (m_busy) begin
      checkOutput("tx_data", obs_data, beatData(model_q[0], m_beat, m_seq));
      checkOutput("tx_last", obs_last, 32'(m_beat == 2));
      if (m_beat == 0 && ready) hdr_seqs.push_back(int'(obs_data[31:24]));
    end

    trace_bus.trace_valid_i       = valid;
    trace_bus.trace_address_i     = r.address;
    trace_bus.trace_destination_i = r.dest;
    trace_bus.trace_result_i      = r.result;
    trace_bus.trace_info_i        = r.info;
    enable_i   = en;
    flush_i    = flush;
    tx_ready_i = ready;

    push  = valid && en && !exp_stall;
    clear = 0;
    if (!m_busy) begin
      if (flush) clear = 1;
      else if (model_q.size() > 0) begin
        m_busy = 1;
        m_beat = 0;
      end
    end else begin
      if (ready) begin
        if (m_beat < 2) m_beat++;
        else begin
          m_busy = 0;
          m_beat = 0;
          if (m_pending || flush) clear = 1;
          else begin
            void'(model_q.pop_front());
            m_seq = (m_seq + 1) % 256;
          end
        end
      end
      if (flush && !clear) m_pending = 1;
    end
    if (clear) begin
      model_q.delete();
      m_seq     = 0;
      m_pending = 0;
    end else if (push) begin
      model_q.push_back(r);
    end
    if (valid && !en && m_dropped < 65535) m_dropped++;
    pushed = push;
    @(posedge clk_i);
  endtask

  task automatic checkResetValues(input string phase);
    checkOutput({phase, "_valid"}, 32'(tx_valid_o), 32'd0);
    checkOutput({phase, "_data"}, tx_data_o, 32'd0);
    checkOutput({phase, "_last"}, 32'(tx_last_o), 32'd0);
    checkOutput({phase, "_stall"}, 32'(trace_bus.trace_stall_o), 32'd0);
    checkOutput({phase, "_dropped"}, 32'(dropped_o), 32'd0);
  endtask

  // Reset is applied while the inputs are busy, to show they are ignored.
  task automatic resetDut();
    trace_bus.trace_valid_i = 1'b1;
    enable_i   = 1'b0;
    flush_i    = 1'b1;
    tx_ready_i = 1'b1;
    rst_n_i    = 1'b0;
    #1;
    checkResetValues("rst");
    repeat (2) begin
      @(negedge clk_i);
      checkResetValues("rst_hold");
    end
    trace_bus.trace_valid_i = 1'b0;
    enable_i   = 1'b1;
    flush_i    = 1'b0;
    tx_ready_i = 1'b0;
    rst_n_i    = 1'b1;
    modelReset();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rec_t r;
    rec_t r4[4];
    bit   p;
    int   guard;
    int   accepted;

    n_checks = 0;
    n_fail   = 0;
    trace_bus.trace_valid_i       = 1'b0;
    trace_bus.trace_address_i     = '0;
    trace_bus.trace_destination_i = '0;
    trace_bus.trace_result_i      = '0;
    trace_bus.trace_info_i        = '0;
    enable_i   = 1'b0;
    flush_i    = 1'b0;
    tx_ready_i = 1'b0;
    rst_n_i    = 1'b1;
    modelReset();
    #1;
    resetDut();

    $display("[TB] single record");
    r = mkRec(32'h0000_1000, 5'd5, 32'hDEAD_BEEF, 8'h03);
    applyStimulus(1, 1, 0, 1, r, p);
    applyStimulus(0, 1, 0, 1, r, p);
    checkOutput("r36_gap", obs_valid, 32'd0);
    applyStimulus(0, 1, 0, 1, r, p);
    checkOutput("r36_hdr_valid", obs_valid, 32'd1);
    checkOutput("r36_hdr", obs_data, 32'h0005_0003);
    applyStimulus(0, 1, 0, 1, r, p);
    checkOutput("r36_addr", obs_data, 32'h0000_1000);
    applyStimulus(0, 1, 0, 1, r, p);
    checkOutput("r36_res", obs_data, 32'hDEAD_BEEF);
    checkOutput("r36_last", obs_last, 32'd1);
    applyStimulus(0, 1, 0, 1, r, p);
    checkOutput("r36_done", obs_valid, 32'd0);

    $display("[TB] backpressure");
    for (int i = 0; i < 8; i++) begin
      r = randRec();
      applyStimulus(1, 1, 0, 0, r, p);
    end
    r = randRec();
    applyStimulus(1, 1, 0, 0, r, p);
    checkOutput("r37_stall_full", obs_stall, 32'd1);
    repeat (3) applyStimulus(1, 1, 0, 0, r, p);
    repeat (3) begin
      applyStimulus(1, 1, 0, 1, r, p);
      checkOutput("r37_held_stall", obs_stall, 32'd1);
    end
    applyStimulus(1, 1, 0, 1, r, p);
    checkOutput("r37_release", obs_stall, 32'd0);
    repeat (45) applyStimulus(0, 1, 0, 1, r, p);
    checkOutput("r37_drained", obs_valid, 32'd0);

    $display("[TB] flush mid-packet");
    for (int i = 0; i < 4; i++) begin
      r4[i] = randRec();
      applyStimulus(1, 1, 0, 0, r4[i], p);
    end
    applyStimulus(0, 1, 0, 1, r, p);
    applyStimulus(0, 1, 1, 0, r, p);
    checkOutput("r40_addr_beat", obs_data, r4[0].address);
    r = randRec();
    applyStimulus(1, 1, 0, 0, r, p);
    checkOutput("r40_stall_pending", obs_stall, 32'd1);
    applyStimulus(0, 1, 0, 1, r, p);
    checkOutput("r40_stall_addr", obs_stall, 32'd1);
    applyStimulus(0, 1, 0, 1, r, p);
    checkOutput("r40_res", obs_data, r4[0].result);
    checkOutput("r40_stall_res", obs_stall, 32'd1);
    applyStimulus(0, 1, 0, 1, r, p);
    checkOutput("r40_idle", obs_valid, 32'd0);
    checkOutput("r40_stall_clear", obs_stall, 32'd0);
    repeat (3) applyStimulus(0, 1, 0, 1, r, p);
    r = randRec();
    applyStimulus(1, 1, 0, 1, r, p);
    applyStimulus(0, 1, 0, 1, r, p);
    applyStimulus(0, 1, 0, 1, r, p);
    checkOutput("r40_seq_reset", {24'd0, obs_data[31:24]}, 32'd0);
    repeat (4) applyStimulus(0, 1, 0, 1, r, p);

    $display("[TB] reset mid-packet");
    r = randRec();
    applyStimulus(1, 1, 0, 0, r, p);
    applyStimulus(0, 1, 0, 0, r, p);
    #2;
    checkOutput("r41_in_header", 32'(tx_valid_o), 32'd1);
    resetDut();

    $display("[TB] disabled capture");
    repeat (3) begin
      applyStimulus(1, 0, 0, 1, randRec(), p);
      applyStimulus(0, 0, 0, 1, r, p);
    end
    applyStimulus(0, 1, 0, 1, r, p);
    checkOutput("r38_dropped", obs_dropped, 32'd3);
    checkOutput("r38_stall", obs_stall, 32'd0);
    checkOutput("r38_no_beat", obs_valid, 32'd0);

    $display("[TB] sequence wrap");
    hdr_seqs.delete();
    accepted = 0;
    guard    = 0;
    r = randRec();
    while (accepted < 257 && guard < 3000) begin
      applyStimulus(1, 1, 0, 1, r, p);
      if (p) begin
        accepted++;
        r = randRec();
      end
      guard++;
    end
    guard = 0;
    while (hdr_seqs.size() < 257 && guard < 100) begin
      applyStimulus(0, 1, 0, 1, r, p);
      guard++;
    end
    checkOutput("r39_count", hdr_seqs.size(), 32'd257);
    if (hdr_seqs.size() >= 257) begin
      checkOutput("r39_first", hdr_seqs[0], 32'd0);
      checkOutput("r39_seq255", hdr_seqs[255], 32'd255);
      checkOutput("r39_wrap", hdr_seqs[256], 32'd0);
    end
    repeat (8) applyStimulus(0, 1, 0, 1, r, p);

    $display("[TB] random traffic");
    r = randRec();
    repeat (2500) begin
      bit v, e, f, rd;
      v  = ($urandom_range(0, 3) != 0);
      e  = ($urandom_range(0, 7) != 0);
      f  = ($urandom_range(0, 59) == 0);
      rd = ($urandom_range(0, 9) < 7);
      applyStimulus(v, e, f, rd, r, p);
      if (p || !v) r = randRec();
    end
    repeat (60) applyStimulus(0, 1, 0, 1, r, p);
    checkOutput("final_idle", obs_valid, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_controller.md
TRACE_CONTROLLER -- requirements
Module: trace_controller

Interface
REQ-001 Parameter DEPTH, default 8, FIFO depth in trace records (power of two, 2..64).
REQ-002 Parameter INFO_W, default 8, width of the packed instruction_status_t info field (at most 16).
REQ-003 clk_i  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous and active-low.
REQ-005 trace_valid_i  input  1  instruction is being written back (trace_interface slave valid).
REQ-006 trace_address_i  input  32  instruction address.
REQ-007 trace_destination_i  input  5  destination register.
REQ-008 trace_result_i  input  32  instruction result.
REQ-009 trace_info_i  input  INFO_W  instruction status info.
REQ-010 trace_stall_o  output  1  trace_interface slave stall; the master holds its record while this is high.
REQ-011 enable_i  input  1  trace capture enable.
REQ-012 flush_i  input  1  single-cycle pulse requesting a buffer flush.
REQ-013 tx_valid_o  output  1  output beat valid.
REQ-014 tx_data_o  output  32  output beat data.
REQ-015 tx_last_o  output  1  last beat of a packet.
REQ-016 tx_ready_i  input  1  downstream accepts the beat.
REQ-017 dropped_o  output  16  count of records discarded while capture was disabled; saturates at 16'hFFFF.

Function
REQ-018 Push: a record SHALL be written when trace_valid_i & enable_i & ~full & ~flush_pending.
REQ-019 Stall: trace_stall_o SHALL equal full | flush_pending. It is combinational from registered state only.
REQ-020 At full, a simultaneous pop SHALL NOT permit a push in the same cycle; the record is accepted the next cycle.
REQ-021 When trace_valid_i is high and enable_i is low, the record SHALL be discarded, stall SHALL stay low, and dropped_o SHALL increment.
REQ-022 FSM states: IDLE, HEADER, ADDRESS, RESULT.
  - IDLE->HEADER when the FIFO is non-empty.
  - HEADER->ADDRESS, ADDRESS->RESULT, and RESULT->IDLE, each on tx_valid_o & tx_ready_i.
REQ-023 HEADER beat: tx_data_o = {seq[7:0], 3'b0, destination[4:0], info zero-extended to 16 bits}.
REQ-024 ADDRESS beat: tx_data_o = address. RESULT beat: tx_data_o = result, with tx_last_o = 1.
REQ-025 tx_valid_o SHALL be high exactly in the HEADER, ADDRESS and RESULT states.
REQ-026 tx_data_o and tx_last_o SHALL hold stable while tx_valid_o & ~tx_ready_i.
REQ-027 The FIFO head SHALL pop on acceptance of the RESULT beat.
REQ-028 seq SHALL increment by 1 on the same event and wrap from 255 to 0.
REQ-029 Latency: a record pushed at edge N into an empty FIFO SHALL present its HEADER beat in the cycle after edge N+1.
REQ-030 FIFO pointers SHALL be log2(DEPTH)+1 bits wide.
  - full = MSBs differ and the lower bits are equal.
  - empty = pointers equal.
REQ-031 Flush in IDLE: a flush_i pulse SHALL clear the FIFO and seq on the next edge.
REQ-032 Flush outside IDLE: flush_pending SHALL be set, and the clear SHALL happen in the cycle RESULT is accepted, together with the return to IDLE. No further record is popped.
REQ-033 Deasserting enable_i SHALL NOT abort a packet in flight or flush buffered records.

Reset
REQ-034 Asynchronous reset SHALL force the following, regardless of state (including mid-packet):
  - FSM = IDLE; FIFO empty; seq = 0; dropped_o = 0; flush_pending = 0.
  - tx_valid_o = 0, tx_data_o = 0, tx_last_o = 0, trace_stall_o = 0.
REQ-035 After reset deassertion, the first accepted record SHALL carry seq = 0.

Verification
REQ-036 Single record, tx_ready_i = 1:
  - stimulus: address 0x0000_1000, dest 5, result 0xDEAD_BEEF, info 0x3.
  - response: beats 0x0005_0003, 0x0000_1000, 0xDEAD_BEEF; last flagged on the third beat.
REQ-037 Backpressure: hold tx_ready_i = 0 and push 8 records.
  - response: stall asserts after the 8th push.
  - A 9th valid is held and accepted only after the first RESULT beat is accepted.
REQ-038 Disabled capture: set enable_i = 0 and pulse valid 3 times.
  - response: dropped_o = 3, no tx beats, stall stays low.
REQ-039 Sequence wrap: send 257 records.
  - response: header seq runs 0..255, then 0.
REQ-040 Flush mid-packet: pulse flush_i during the ADDRESS beat with 4 records queued.
  - response: the current packet completes, then the FIFO is empty and seq = 0.
  - Stall stays high until that point.
REQ-041 Reset mid-packet: assert rst_n_i = 0 during HEADER.
  - response: tx_valid_o = 0 immediately, and all outputs hold their reset values until release.
